// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the small alignment helpers used by both the controller and the datapath.
package lsu_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;
    localparam int ADS_W  = 6;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // An access is aligned when the low log2(size) address bits are all zero.
    function automatic logic is_misaligned(input logic [2:0] offset, input size_e size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input size_e size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane datapath: extracts and extends load data from a
// doubleword, and merges right-aligned store data into the addressed bytes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] i_dword,
    input  logic [2:0]        i_offset,
    input  size_e             i_size,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_merged
);

    logic [5:0]        w_shamt;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_mask;

    assign w_shamt = {i_offset, 3'b000};
    assign w_lane  = i_dword >> w_shamt;
    assign w_mask  = lane_mask(i_size) << w_shamt;

    always_comb begin
        // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
        o_rdata = w_lane;
        case (i_size)
            SZ_B:    o_rdata = {{56{w_lane[7]  & ~i_unsigned}}, w_lane[7:0]};
            SZ_H:    o_rdata = {{48{w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            SZ_W:    o_rdata = {{32{w_lane[31] & ~i_unsigned}}, w_lane[31:0]};
            default: o_rdata = w_lane;
        endcase
    end

    assign o_merged = (i_dword & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a synchronous doubleword memory;
// sub-doubleword stores are performed as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADS_W-1:0]  mem_ads,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    size_e             r_size;
    logic              r_we;
    logic              r_unsigned;
    logic              r_err;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_dword;

    size_e             w_req_size;
    logic              w_misaligned;
    logic              w_mem_phase;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_merged;

    assign w_req_size   = size_e'(req_size);
    assign w_misaligned = is_misaligned(req_addr[2:0], w_req_size);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= SZ_B;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_dword    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_size     <= w_req_size;
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_err      <= w_misaligned;
                        if (w_misaligned)
                            r_state <= RESP;
                        else if (req_we && w_req_size == SZ_D)
                            r_state <= WR;
                        else
                            r_state <= RD;
                    end
                end
                RD:  r_state <= CAP;
                CAP: begin
                    r_dword <= mem_dout;
                    r_state <= r_we ? WR : RESP;
                end
                WR:      r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    lsu_align u_align (
        .i_dword    (r_dword),
        .i_offset   (r_addr[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_rdata    (w_rdata),
        .o_merged   (w_merged)
    );

    // Outputs decode the registered state only, so reset clears them at once.
    assign w_mem_phase = (r_state == RD) || (r_state == CAP) || (r_state == WR);
    assign req_ready   = (r_state == IDLE);
    assign mem_ads     = w_mem_phase ? r_addr[ADDR_W-1:3] : '0;
    assign mem_we      = (r_state == WR);
    assign mem_din     = mem_we ? w_merged : '0;
    assign resp_valid  = (r_state == RESP);
    assign resp_err    = resp_valid & r_err;
    assign resp_rdata  = (resp_valid && !r_err && !r_we) ? w_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed
// corner cases followed by randomized loads and stores.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  mem_ads;
    logic        mem_we;
    logic [63:0] mem_din;
    logic [63:0] mem_dout = '0;

    logic [63:0] mem [64];
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [63:0] bd_data = '0;

    logic [7:0]  ref_bytes [512];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          we_cnt = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          we_base;
        int          exp_we;
        logic [5:0]  ads;
    } exp_t;

    exp_t sb [$];
    exp_t got;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ads      (mem_ads),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous doubleword memory with a backdoor port for preloading.
    always @(posedge clk) begin
        if (bd_en)
            mem[bd_idx] <= bd_data;
        else if (mem_we)
            mem[mem_ads] <= mem_din;
        else
            mem_dout <= mem[mem_ads];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input int addr, input int size, input bit uns);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[addr + i];
        if (!uns && n < 8 && v[8*n-1])
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] ref_entry(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[idx*8 + i];
        return v;
    endfunction

    task automatic set_entry(input int idx, input logic [63:0] d);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_idx  = 6'(idx);
        bd_data = d;
        @(posedge clk);
        #1 bd_en = 1'b0;
        for (int i = 0; i < 8; i++) ref_bytes[idx*8 + i] = d[8*i +: 8];
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                if (sb.size() > 0) check("mem_ads", 64'(mem_ads), 64'(sb[0].ads));
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(sb.size()), 64'd1);
                end else begin
                    got = sb.pop_front();
                    check("resp_rdata", resp_rdata, got.rdata);
                    check("resp_err", 64'(resp_err), 64'(got.err));
                    check("latency", 64'(cyc - got.acc + 1), 64'(got.lat));
                    check("we_pulses", 64'(we_cnt - got.we_base), 64'(got.exp_we));
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("resp_timeout", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic issue(input bit we, input int size, input int addr, input bit uns,
                         input logic [63:0] wdata);
        exp_t e;
        int   n;
        bit   mis;
        n       = 1 << size;
        mis     = (addr % n) != 0;
        e.err   = mis;
        e.rdata = (!we && !mis) ? ref_load(addr, size, uns) : 64'd0;
        e.lat   = mis ? 1 : (we ? ((size == 3) ? 2 : 4) : 3);
        e.exp_we = (we && !mis) ? 1 : 0;
        e.ads   = 6'(addr >> 3);
        if (we && !mis)
            for (int i = 0; i < n; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
        @(negedge clk);
        wait_ready();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = 2'(size);
        req_addr     = 9'(addr);
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.acc     = cyc;
        e.we_base = we_cnt;
        sb.push_back(e);
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 64; i++) set_entry(i, {$urandom, $urandom});

        // Outputs while reset is held.
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_ads", 64'(mem_ads), 64'd0);
        check("rst_mem_din", mem_din, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_reset", 64'(req_ready), 64'd1);

        set_entry(16, 64'h2D);
        issue(1'b0, 3, 'h080, 1'b0, 64'd0);

        set_entry(2, 64'h0000_0000_0000_8000);
        issue(1'b0, 1, 'h010, 1'b0, 64'd0);
        issue(1'b0, 1, 'h010, 1'b1, 64'd0);

        set_entry(3, 64'h1111_1111_1111_1111);
        issue(1'b1, 0, 'h01A, 1'b0, 64'hAB);
        check("entry3_after_store_b", mem[3], 64'h1111_1111_11AB_1111);

        issue(1'b1, 2, 'h006, 1'b0, 64'h0123_4567_89AB_CDEF);
        check("entry0_after_misaligned", mem[0], ref_entry(0));

        issue(1'b1, 3, 'h0F8, 1'b0, 64'hDEAD_BEEF_0000_0001);
        check("entry31_after_store_d", mem[31], 64'hDEAD_BEEF_0000_0001);
        issue(1'b0, 3, 'h0F8, 1'b0, 64'd0);

        // Reset during CAP of a byte store abandons it without a response.
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 9'h021;
        req_wdata = 64'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        base = we_cnt;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_mem_ads", 64'(mem_ads), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_ready", 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("midrst_no_write", 64'(we_cnt - base), 64'd0);
        check("midrst_entry4", mem[4], ref_entry(4));

        for (int t = 0; t < 150; t++) begin
            int  size;
            int  addr;
            bit  we_b;
            bit  uns_b;
            size  = int'($urandom_range(0, 3));
            addr  = int'($urandom_range(0, 511));
            we_b  = 1'($urandom_range(0, 1));
            uns_b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << size) - 1);
            issue(we_b, size, addr, uns_b, {$urandom, $urandom});
        end

        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_entry(i));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1, a request is present.
REQ-004 SHALL have port req_ready, output, 1, the unit accepts a request this cycle.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 9, byte address.
REQ-007 SHALL have port req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 SHALL have port req_unsigned, input, 1, zero-extend loads.
REQ-009 SHALL have port req_wdata, input, 64, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 64, extended load data; 0 for stores.
REQ-012 SHALL have port resp_err, output, 1, misaligned request.
REQ-013 SHALL have port mem_ads, output, 6, doubleword index to the memory.
REQ-014 SHALL have port mem_we, output, 1, memory write enable.
REQ-015 SHALL have port mem_din, output, 64, memory write data.
REQ-016 SHALL have port mem_dout, input, 64, memory read data; valid one edge after an edge with mem_we=0.

Function
REQ-017 SHALL use the FSM states IDLE, RD, CAP, WR and RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE and accept a request on an edge where req_valid and req_ready are both 1, latching addr, size, we, unsigned and wdata.
REQ-019 SHALL flag an accepted request as misaligned when addr is not a multiple of 2^size; misaligned requests go IDLE->RESP with resp_err=1, no mem_we pulse and resp_rdata=0.
REQ-020 SHALL route aligned loads IDLE->RD->CAP->RESP: resp_valid is high 3 cycles after the accept edge.
REQ-021 SHALL route aligned double stores IDLE->WR->RESP.
REQ-022 SHALL route aligned sub-double stores IDLE->RD->CAP->WR->RESP, a read-modify-write that replaces only the addressed bytes.
REQ-023 SHALL drive mem_ads = latched addr[8:3] in RD, CAP and WR, and 0 otherwise.
REQ-024 SHALL drive mem_we=1 only in WR.
REQ-025 SHALL drive mem_din only in WR, as the merged doubleword, and 0 otherwise.
REQ-026 SHALL capture mem_dout into an internal doubleword register in CAP.
REQ-027 SHALL select load data from byte lane addr[2:0] (little-endian) and extend it by size: sign-extend when req_unsigned=0, zero-extend when 1; size 3 ignores unsigned.
REQ-028 SHALL assert resp_valid for exactly one cycle, in RESP, with resp_rdata and resp_err stable during that cycle; RESP->IDLE unconditionally.
REQ-029 SHALL ignore req_valid outside IDLE; no queueing, and back-to-back requests see one idle cycle minimum.
REQ-030 SHALL keep mem_we=0 in every state except WR, so no write occurs during RD/CAP.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE.
REQ-032 SHALL, while rst_n=0, immediately force resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_ads=0, mem_din=0 and all latched registers to 0.
REQ-033 SHALL abandon an in-flight request without a response when reset is asserted mid-operation, including in WR.
REQ-034 SHALL drive req_ready=1 in the first cycle after reset deassertion.

Structure
REQ-035 SHALL place the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state encoding in shared package lsu_pkg.
REQ-036 SHALL implement lane select/extension and store-byte merge in a combinational sub-module lsu_align, instantiated once.
REQ-037 SHALL keep all sequential logic in load_store_unit.

Verification
REQ-038 SHALL cover: memory entry 16 = 64'h2D, load D addr 9'h080 -> resp_valid 3 cycles after accept, rdata=64'h2D, err=0.
REQ-039 SHALL cover: entry 2 = 64'h0000_0000_0000_8000, load H signed addr 9'h010 -> rdata=64'hFFFF_FFFF_FFFF_8000; same request unsigned -> 64'h8000.
REQ-040 SHALL cover: entry 3 = 64'h1111_1111_1111_1111, store B wdata 8'hAB addr 9'h01A -> exactly one mem_we pulse, entry 3 = 64'h1111_1111_11AB_1111.
REQ-041 SHALL cover: store W addr 9'h006 -> resp_err=1 after 1 cycle, no mem_we, memory unchanged.
REQ-042 SHALL cover: store D 64'hDEAD_BEEF_0000_0001 addr 9'h0F8 -> resp 2 cycles after accept, entry 31 written; then load D reads it back.
REQ-043 SHALL cover: assert rst_n=0 during CAP of a byte store -> no mem_we, no resp_valid, req_ready=1 after release.
